mem_access_unit: RTL

- Sits directly upstream of the word-wide data memory in the single-cycle MIPS datapath.
- Converts CPU load/store requests (lb/lbu/lh/lhu/lw/sb/sh/sw) into word-aligned memory accesses.
- Loads: extracts the addressed lane and sign- or zero-extends it.
- Sub-word stores: performed as read-modify-write, because the memory only writes full words.
- CPU-side request/response handshake; stalls the core while busy.

---
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns CPU lb/lbu/lh/lhu/lw/sb/sh/sw requests into word-aligned
// accesses on a word-wide data memory. Loads pick the addressed lane and extend it.
// Sub-word stores are done as read-modify-write because the memory only writes
// whole words.
// Optional feature: define MAU_BOUNDS_CHECK_EN to reject word addresses >= MEM_WORDS.

module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StLd,
    StSt,
    StRmwRd,
    StRmwWr,
    StDone,
    StErr
  } state_e;

`ifdef MAU_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  state_e      state_q;
  logic [1:0]  lo_q;     // byte offset within the word
  logic [1:0]  size_q;
  logic        uns_q;
  logic [15:0] wdata_q;  // only the sub-word part is needed for the merge

  logic        misalign;
  logic        oob;
  logic        illegal;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign req_ready = (state_q == StIdle);

  // Classify the incoming request: alignment, illegal size and optional range
  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b1;
    endcase
    oob     = BoundsEn && ({2'b00, req_addr[31:2]} >= MEM_WORDS);
    illegal = misalign || oob;
  end

  // Lane select and sign/zero extension of the memory word for loads
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (lo_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Replace the addressed byte/half of the read word with the store data
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      case (lo_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lo_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Control FSM; strobes and response flags are registered alongside the state
  // so they are a pure function of which state the unit is in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lo_q      <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      wdata_q   <= 16'h0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            lo_q     <= req_addr[1:0];
            size_q   <= req_size;
            uns_q    <= req_unsigned;
            wdata_q  <= req_wdata[15:0];
            mem_addr <= {req_addr[31:2], 2'b00};
            if (illegal) begin
              state_q   <= StErr;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (!req_write) begin
              state_q  <= StLd;
              mem_read <= 1'b1;
            end else if (req_size == 2'b10) begin
              state_q   <= StSt;
              mem_write <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state_q  <= StRmwRd;
              mem_read <= 1'b1;
            end
          end
        end
        StLd: begin
          rsp_rdata <= load_ext;
          rsp_valid <= 1'b1;
          state_q   <= StDone;
        end
        StSt: begin
          rsp_valid <= 1'b1;
          state_q   <= StDone;
        end
        StRmwRd: begin
          // mem_wdata doubles as the merge register
          mem_wdata <= merged;
          mem_write <= 1'b1;
          state_q   <= StRmwWr;
        end
        StRmwWr: begin
          rsp_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
